seq_pattern_gen: RTL and testbench
==================================

# seq_pattern_gen

Moore-style serial pattern generator: captures an N-bit pattern on a start strobe and shifts it out MSB-first, one bit per clock, optionally repeated with an idle gap between repetitions. It is the transmit-side companion to the team's Moore sequence detectors, such as the 101 detector. Its serial output drives a detector's `x` input directly for stimulus and loopback. All outputs are decoded from registered state and counters; no input reaches an output combinationally.

## Interface
- `WIDTH`, 8: maximum pattern length in bits.
- `CNT_W`, 4: width of the repetition count.
- `GAP`, 2: idle cycles inserted between repetitions; 0 means back-to-back.
- `clk`, input, 1: single clock; all state updates on posedge.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request; sampled only in IDLE.
- `pattern`, input, WIDTH: bits to send; the used field is `pattern[nbits-1:0]`.
- `nbits`, input, $clog2(WIDTH+1): number of bits per repetition.
- `reps`, input, CNT_W: number of repetitions.
- `x`, output, 1: serial data; 0 whenever `x_valid`=0.
- `x_valid`, output, 1: `x` carries a pattern or parity bit this cycle.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: single-cycle pulse after the final bit.

## Operation
- States:
  - IDLE: wait for `start`.
  - SHIFT: drive one pattern bit per cycle.
  - PAR: drive one parity bit; exists only with the configuration macro.
  - GAP: idle between repetitions.
  - DONE: one cycle with `done`=1.
- IDLE with `start`=1:
  - Capture `pattern`, `nbits` and `reps` into internal registers.
  - Then go to SHIFT.
- Input clamping at capture: `nbits`=0 becomes 1; `nbits`>WIDTH becomes WIDTH; `reps`=0 becomes 1.
- SHIFT:
  - Bit index runs from nbits-1 down to 0.
  - `x` is the captured bit at the current index; `x_valid`=1.
  - After index 0, go to PAR if enabled. Otherwise go to GAP when repetitions remain, else DONE.
- GAP:
  - Stay GAP cycles with `x`=0 and `x_valid`=0, then return to SHIFT with the index reloaded.
  - GAP=0 skips this state entirely.
- DONE: lasts one cycle, then IDLE.
- Inputs are ignored while `busy`=1. Captured values are stable for the whole job.
- `start` held high continuously: a new job is captured on the first IDLE cycle after DONE.

## Timing
- Reset, asynchronous, effective immediately, including mid-transfer:
  - State goes to IDLE.
  - `x`=0, `x_valid`=0, `busy`=0, `done`=0.
  - Counters and captured registers go to 0.
- Cycle numbering: `start` is sampled at edge E0. The first bit is valid in the cycle after E0 (latency 1).
- One repetition occupies nbits cycles, plus 1 cycle when parity is enabled.
- Total job length is R·(nbits+P) + (R−1)·GAP cycles with `busy`=1 and data flowing, followed by 1 DONE cycle. R is the clamped rep count; P is 1 with parity, else 0.
- `busy` rises in the cycle after E0 and falls in the cycle after DONE.
- `done` is never coincident with `x_valid`.
- Counter widths:
  - Bit index: $clog2(WIDTH).
  - Gap counter: $clog2(GAP+1), minimum 1.
  - Rep counter: CNT_W, decrementing. The last repetition is detected at value 1; there is no wrap.

## Configuration
- `SEQ_GEN_PARITY_EN` defined:
  - PAR state is compiled in.
  - After each repetition, one extra bit equal to the even parity (XOR) of the sent nbits bits is driven with `x_valid`=1.
- Undefined: PAR state, the parity accumulator and P are absent (P=0).

## Structure
- A shared package `seq_gen_pkg` holds:
  - the state enum typedef (IDLE, SHIFT, PAR, GAP, DONE);
  - the state width constant;
  - the clamp helper function for `nbits` and `reps`.
- Single sub-module `seq_gen_shreg`: loadable MSB-first shift register with a bit counter. The FSM, gap counter, rep counter and parity live in the top level.

## Test plan
- WIDTH=8, `pattern`=8'b0000_0101, `nbits`=3, `reps`=1, pulse `start` -> `x`=1,0,1 on cycles 1–3 with `x_valid`=1. `done`=1 on cycle 4; `busy` low from cycle 5. Looped into the 101 Moore detector, its output `y` rises once.
- `pattern`=8'hA5, `nbits`=8, `reps`=3, GAP=2 -> three copies of 1010_0101, each separated by 2 cycles of `x_valid`=0. The job is 28 busy cycles with data, then `done`.
- `nbits`=0 and `reps`=0 -> exactly one bit (`pattern[0]`) is sent, then `done`. `nbits`=15 is clamped to 8 bits.
- `start` pulsed at mid-transfer with a different `pattern` -> ignored; the original stream completes unchanged.
- `rst` driven low at bit 4 of 8 -> `x`, `x_valid` and `busy` drop to 0 without waiting for a clock edge, and no `done` is produced. A `start` after release yields a full, correct job.
- With `SEQ_GEN_PARITY_EN`, `pattern`=3'b101, `nbits`=3, `reps`=2, GAP=0 -> serial stream 1,0,1,0,1,0,1,0, where each repetition's parity bit is 0. `done` follows the 8th bit.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// -----------------------------------------------------------------------------
// seq_gen_pkg
//   Shared definitions for the serial pattern generator:
//     - STATE_W : width of the FSM state register
//     - state_t : FSM state encoding (IDLE, SHIFT, PAR, GAP, DONE)
//     - clamp_range() : saturates a requested length/count into [lo, hi]
//   Optional feature macro: SEQ_GEN_PARITY_EN (adds the PAR state).
// -----------------------------------------------------------------------------
package seq_gen_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
`ifdef SEQ_GEN_PARITY_EN
    S_PAR   = 3'd2,
`endif
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Used at capture so a job never has zero bits or zero repetitions and
  // never reads beyond the pattern register.
  function automatic int clamp_range(input int val, input int lo, input int hi);
    if (val < lo) return lo;
    if (val > hi) return hi;
    return val;
  endfunction

endpackage

// File: rtl/seq_gen_shreg.sv
// -----------------------------------------------------------------------------
// seq_gen_shreg
//   Loadable MSB-first shift register with a bit-index counter.
//   On load the used field load_data[load_len-1:0] is left-aligned so the
//   bit to send is always at the top of the register.
//   Ports:
//     clk, rst   : clock, asynchronous active-low reset
//     load       : capture load_data/load_len (has priority over shift)
//     shift      : advance to the next bit
//     load_data  : pattern bits (used field is the low load_len bits)
//     load_len   : number of bits, 1..WIDTH (already clamped by caller)
//     dout       : current serial bit
//     last       : current bit is index 0 (final bit of the repetition)
// -----------------------------------------------------------------------------
module seq_gen_shreg #(
  parameter  int WIDTH = 8,
  localparam int LEN_W = $clog2(WIDTH + 1),
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  output logic             dout,
  output logic             last
);

  logic [WIDTH-1:0] data;
  logic [IDX_W-1:0] idx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
      idx  <= '0;
    end else if (load) begin
      data <= load_data << (WIDTH - int'(load_len));
      idx  <= IDX_W'(int'(load_len) - 1);
    end else if (shift) begin
      data <= data << 1;
      idx  <= idx - 1'b1;
    end
  end

  assign dout = data[WIDTH-1];
  assign last = (idx == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// seq_pattern_gen
//   Moore serial pattern generator. On start (sampled in IDLE) it captures
//   pattern/nbits/reps and shifts pattern[nbits-1:0] out MSB-first, one bit
//   per clock, reps times, with GAP idle cycles between repetitions.
//   Outputs are decoded from registered state only.
//   Optional macro SEQ_GEN_PARITY_EN: an even-parity bit follows each
//   repetition.
//   Ports:
//     clk, rst : clock, asynchronous active-low reset
//     start    : job request (ignored while busy)
//     pattern  : bits to send
//     nbits    : bits per repetition (0 -> 1, >WIDTH -> WIDTH)
//     reps     : repetitions (0 -> 1)
//     x        : serial data, 0 when x_valid is 0
//     x_valid  : x carries a pattern or parity bit
//     busy     : high in every state except IDLE
//     done     : one-cycle pulse after the final bit
// -----------------------------------------------------------------------------
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int CNT_W = 4,
  parameter  int GAP   = 2,
  localparam int NB_W  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [NB_W-1:0]  nbits,
  input  logic [CNT_W-1:0] reps,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_t           state;
  logic [WIDTH-1:0] cap_pat;
  logic [NB_W-1:0]  cap_nbits;
  logic [CNT_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_cnt;
`ifdef SEQ_GEN_PARITY_EN
  logic             par_acc;
`endif

  logic [NB_W-1:0]  nbits_cl;
  logic [CNT_W-1:0] reps_cl;
  logic             more_reps;
  state_t           after_rep;
  logic             sh_load;
  logic             sh_shift;
  logic [WIDTH-1:0] sh_data;
  logic [NB_W-1:0]  sh_len;
  logic             sh_dout;
  logic             sh_last;

  assign nbits_cl  = NB_W'(clamp_range(int'(nbits), 1, WIDTH));
  assign reps_cl   = CNT_W'(clamp_range(int'(reps), 1, (1 << CNT_W) - 1));
  assign more_reps = (rep_cnt != CNT_W'(1));

  // Where the FSM goes once a repetition (data plus optional parity) ends,
  // and whether the shift register must be reloaded for the next one.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    after_rep = S_DONE;
    if (more_reps) after_rep = (GAP == 0) ? S_SHIFT : S_GAP;

    sh_load = 1'b0;
    case (state)
      S_IDLE:  sh_load = start;
`ifdef SEQ_GEN_PARITY_EN
      S_PAR:   sh_load = (after_rep == S_SHIFT);
`else
      S_SHIFT: sh_load = sh_last && (after_rep == S_SHIFT);
`endif
      S_GAP:   sh_load = (gap_cnt == '0);
      default: sh_load = 1'b0;
    endcase
  end

  assign sh_shift = (state == S_SHIFT);
  // First load comes straight from the inputs; reloads use the captured copy.
  assign sh_data  = (state == S_IDLE) ? pattern  : cap_pat;
  assign sh_len   = (state == S_IDLE) ? nbits_cl : cap_nbits;

  seq_gen_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .shift     (sh_shift),
    .load_data (sh_data),
    .load_len  (sh_len),
    .dout      (sh_dout),
    .last      (sh_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cap_pat   <= '0;
      cap_nbits <= '0;
      rep_cnt   <= '0;
      gap_cnt   <= '0;
`ifdef SEQ_GEN_PARITY_EN
      par_acc   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cap_pat   <= pattern;
            cap_nbits <= nbits_cl;
            rep_cnt   <= reps_cl;
            state     <= S_SHIFT;
`ifdef SEQ_GEN_PARITY_EN
            par_acc   <= 1'b0;
`endif
          end
        end
        S_SHIFT: begin
`ifdef SEQ_GEN_PARITY_EN
          par_acc <= par_acc ^ sh_dout;
          if (sh_last) state <= S_PAR;
`else
          if (sh_last) begin
            state   <= after_rep;
            gap_cnt <= GAP_LOAD;
            if (more_reps) rep_cnt <= rep_cnt - 1'b1;
          end
`endif
        end
`ifdef SEQ_GEN_PARITY_EN
        S_PAR: begin
          par_acc <= 1'b0;
          state   <= after_rep;
          gap_cnt <= GAP_LOAD;
          if (more_reps) rep_cnt <= rep_cnt - 1'b1;
        end
`endif
        S_GAP: begin
          if (gap_cnt == '0) state <= S_SHIFT;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    x       = 1'b0;
    x_valid = 1'b0;
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    if (state == S_SHIFT) begin
      x       = sh_dout;
      x_valid = 1'b1;
    end
`ifdef SEQ_GEN_PARITY_EN
    if (state == S_PAR) begin
      x       = par_acc;
      x_valid = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_gen
//   Self-checking bench for seq_pattern_gen (WIDTH=8, CNT_W=4, GAP=2).
//   Each job's cycle-by-cycle output {busy, x_valid, x, done} is predicted
//   from the stream definition (bits nbits-1..0, optional parity, gaps,
//   one done cycle, then idle) and compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_seq_pattern_gen;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int GAP   = 2;
  localparam int NB_W  = $clog2(WIDTH + 1);
`ifdef SEQ_GEN_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] pattern = '0;
  logic [NB_W-1:0]  nbits = '0;
  logic [CNT_W-1:0] reps = '0;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  seq_pattern_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP(GAP)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .nbits   (nbits),
    .reps    (reps),
    .x       (x),
    .x_valid (x_valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] obs();
    return {busy, x_valid, x, done};
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got {busy,vld,x,done}=%b exp=%b", tag, got, exp);
    end
  endtask

  // Expected stream for one job, starting with the cycle after start is sampled.
  task automatic build_expected(input logic [WIDTH-1:0] pat, input int nb, input int rp);
    int n, r;
    bit p;
    exp_q.delete();
    n = (nb < 1) ? 1 : ((nb > WIDTH) ? WIDTH : nb);
    r = (rp < 1) ? 1 : rp;
    for (int k = 0; k < r; k++) begin
      p = 1'b0;
      for (int i = n - 1; i >= 0; i--) begin
        exp_q.push_back({1'b1, 1'b1, pat[i], 1'b0});
        p ^= pat[i];
      end
      if (PAR_EN) exp_q.push_back({1'b1, 1'b1, p, 1'b0});
      if (k < r - 1)
        for (int g = 0; g < GAP; g++) exp_q.push_back(4'b1000);
    end
    exp_q.push_back(4'b1001);   // DONE
    exp_q.push_back(4'b0000);   // back in IDLE
  endtask

  // Called on a falling edge with the DUT idle; returns on the falling edge
  // of the first IDLE cycle after DONE.
  task automatic run_job(input string name, input logic [WIDTH-1:0] pat, input int nb,
                         input int rp, input bit inject, input bit hold);
    int inj_at;
    build_expected(pat, nb, rp);
    inj_at  = (inject && exp_q.size() > 3) ? $urandom_range(0, exp_q.size() - 3) : -1;
    pattern = pat;
    nbits   = NB_W'(nb);
    reps    = CNT_W'(rp);
    start   = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s cyc%0d", name, i + 1), obs(), exp_q[i]);
      if (i == inj_at) begin
        start   = 1'b1;
        pattern = ~pat;
        nbits   = NB_W'($urandom_range(1, WIDTH));
        reps    = CNT_W'($urandom_range(1, 3));
      end else if (i == inj_at + 1 && !hold) begin
        start = 1'b0;
      end
      if (i < exp_q.size() - 1) @(negedge clk);
    end
  endtask

  initial begin
    // Asynchronous reset with no clock edge yet.
    #1 rst = 1'b0;
    #1 check("reset_async", obs(), 4'b0000);
    @(negedge clk);
    check("reset_held", obs(), 4'b0000);
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", obs(), 4'b0000);

    // Directed jobs.
    run_job("p101",      8'b0000_0101, 3, 1, 1'b0, 1'b0);
    run_job("a5x3",      8'hA5,        8, 3, 1'b0, 1'b0);
    run_job("clamp0",    8'h5B,        0, 0, 1'b0, 1'b0);
    run_job("clamp15",   8'h3C,       15, 1, 1'b0, 1'b0);
    run_job("ign_start", 8'hC3,        8, 2, 1'b1, 1'b0);
    run_job("hold_a",    8'h96,        5, 2, 1'b0, 1'b1);
    run_job("hold_b",    8'h71,        4, 1, 1'b0, 1'b0);

    // Reset in the middle of a transfer: after 4 of 8 bits.
    build_expected(8'hE7, 8, 1);
    pattern = 8'hE7; nbits = NB_W'(8); reps = CNT_W'(1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mid_rst bit%0d", i + 1), obs(), exp_q[i]);
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1 check("mid_rst_async", obs(), 4'b0000);
    @(negedge clk);
    check("mid_rst_held", obs(), 4'b0000);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("mid_rst_quiet%0d", i), obs(), 4'b0000);
    end
    run_job("after_rst", 8'h5A, 8, 2, 1'b0, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 30; j++) begin
      run_job($sformatf("rnd%0d", j), WIDTH'($urandom), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
              (j < 29) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    start = 1'b0;
    @(negedge clk);
    check("final_idle", obs(), 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
